// File: rtl/usr_pkg.sv
// Shared types for the burst shifter: operation modes, FSM states and a mode classifier.
package usr_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'b000,
        SHR  = 3'b001,
        SHL  = 3'b010,
        LOAD = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Modes that consume cmd_amount and may take several steps.
    function automatic logic is_shift_mode(input usr_mode_e mode);
        return (mode == SHR) || (mode == SHL) || (mode == ROR) ||
               (mode == ROL) || (mode == ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One step of the universal shift register: next register value for a given mode.
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  usr_mode_e        mode_i,
    input  logic             ser_in_msb_i,
    input  logic             ser_in_lsb_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] q_next_o
);

    // Decode the mode into a single-step result.
    always_comb begin
        q_next_o = q_i;
        unique case (mode_i)
            NOP:     q_next_o = q_i;
            SHR:     q_next_o = {ser_in_msb_i, q_i[WIDTH-1:1]};
            SHL:     q_next_o = {q_i[WIDTH-2:0], ser_in_lsb_i};
            LOAD:    q_next_o = data_in_i;
            ROR:     q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            ROL:     q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            ASR:     q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            CLR:     q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/usr_burst_shifter.sv
// Universal shift register with a command handshake and multi-step burst shifts.
module usr_burst_shifter
    import usr_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    usr_mode_e        mode_q, mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    usr_mode_e        cmd_mode_e;
    usr_mode_e        step_mode;
    logic [WIDTH-1:0] step_q;

    assign cmd_mode_e = usr_mode_e'(cmd_mode);
    // In IDLE the step unit serves the incoming command; in SHIFT the latched mode.
    assign step_mode  = (state_q == SHIFT) ? mode_q : cmd_mode_e;

    usr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q_i         (data_q),
        .mode_i      (step_mode),
        .ser_in_msb_i(ser_in_msb),
        .ser_in_lsb_i(ser_in_lsb),
        .data_in_i   (data_in),
        .q_next_o    (step_q)
    );

    // Next-state logic: accept in IDLE, one step per cycle in SHIFT.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (is_shift_mode(cmd_mode_e)) begin
                        if (cmd_amount == '0) begin
                            done_d = 1'b1;
                        end else begin
                            data_d = step_q;
                            mode_d = cmd_mode_e;
                            cnt_d  = cmd_amount - AMT_W'(1);
                            if (cmd_amount == AMT_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SHIFT;
                            end
                        end
                    end else begin
                        data_d = step_q;
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                data_d = step_q;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= NOP;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q == SHIFT);
    assign done        = done_q;
    assign data_out    = data_q;
    assign ser_out_msb = data_q[WIDTH-1];
    assign ser_out_lsb = data_q[0];

endmodule

// File: doc/usr_burst_shifter.md
Name: usr_burst_shifter

Overview:
Parametrised universal shift register with a command handshake and multi-bit burst shifts.
- Each accepted command carries a mode and a shift amount.
- The block performs one bit-shift per clock until the amount is exhausted, then pulses done.
- Adds rotate, arithmetic shift, clear and serial in/out at both ends, so it can serve as a serialiser/deserialiser or a bit-manipulation engine in datapath blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field. Derived; do not override.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_mode  in  3  operation, per mode table
- cmd_amount  in  AMT_W  shift count for shift/rotate modes; ignored otherwise
- data_in  in  WIDTH  parallel load value
- ser_in_msb  in  1  fill bit entering the MSB on SHR
- ser_in_lsb  in  1  fill bit entering the LSB on SHL
- data_out  out  WIDTH  register contents
- ser_out_msb  out  1  data_out[WIDTH-1], combinational
- ser_out_lsb  out  1  data_out[0], combinational
- busy  out  1  high while in SHIFT state
- done  out  1  one-cycle pulse when a command completes

Behaviour:
Mode table:
- 000 NOP
- 001 SHR: {ser_in_msb, q[W-1:1]}
- 010 SHL: {q[W-2:0], ser_in_lsb}
- 011 LOAD: data_in
- 100 ROR: {q[0], q[W-1:1]}
- 101 ROL: {q[W-2:0], q[W-1]}
- 110 ASR: {q[W-1], q[W-1:1]}
- 111 CLR: all zeros

Reset: data_out=0, state=IDLE, busy=0, done=0, cmd_ready=1. Reset has priority over everything, including a command in progress. A burst in flight is aborted, with no done pulse.

Accept: a command is accepted at a rising edge where cmd_valid && cmd_ready. cmd_ready = (state==IDLE). cmd_valid while busy is ignored, not queued.

NOP, LOAD, CLR, and any shift/rotate mode with amount=0:
- Operation applied at the accept edge T (NOP and amount=0 leave data_out unchanged).
- done=1 for the cycle after T; state stays IDLE.

Shift/rotate modes with amount=k>=1:
- First step applied at accept edge T. Mode is latched, remaining counter = k-1.
- If k=1: done=1 the cycle after T; stay IDLE.
- Else go to SHIFT. One step per edge; counter decrements each step. At the edge that applies step k, return to IDLE with done=1 in the following cycle.
- busy=1 for exactly k-1 cycles.

Serial inputs are sampled at every step edge, so streaming data can change per cycle. Amounts >= WIDTH are legal: rotates wrap naturally; SHR/SHL simply keep shifting in fill bits.

Back-to-back: the done cycle is also an IDLE cycle, so a new command may be accepted in it. Throughput is one command per cycle for single-step operations.

data_in and cmd_* are don't-care when not accepted.

State machine: IDLE <-> SHIFT only. done is a registered pulse, never high for two consecutive cycles from one command.

Decomposition:
- Package usr_pkg: typedef enum logic [2:0] usr_mode_e (NOP, SHR, SHL, LOAD, ROR, ROL, ASR, CLR); typedef enum state_e {IDLE, SHIFT}.
- Sub-module usr_step: parametrised WIDTH, purely combinational. Inputs: q, mode, ser_in_msb, ser_in_lsb, data_in. Output: next q. Shared by the accept path and the SHIFT path.
- Top module holds the FSM, counter, mode latch and the done register.

Test Plan:
1. Assert reset 2 cycles, release -> data_out=8'h00, busy=0, done=0, cmd_ready=1. Apply reset during an active burst -> same values on the next edge.
2. LOAD data_in=8'hA5 -> data_out=8'hA5 one edge later; done high exactly one cycle; busy never high.
3. From 8'hA5, SHL amount=3, ser_in_lsb=1 -> data_out 4B, 97, 2F on successive edges; busy high 2 cycles; done then; cmd_valid with CLR held during busy is ignored until ready.
4. From 8'h96, ASR amount=2 -> 8'hE5. From 8'h81, ROL amount=9 -> 8'h03 after 9 steps, with done on the 9th-step cycle+1.
5. ROR amount=0 from 8'h3C -> data_out stays 3C, done next cycle. A back-to-back command issued in the done cycle is accepted that cycle.
6. SHR amount=8 with ser_in_msb driven 1,0,1,1,0,0,1,0 per cycle from 8'h00 -> data_out=8'h4D (first bit ends in LSB), ser_out_lsb tracks data_out[0] each cycle.
